// File: rtl/game_pkg.sv
// Shared constants and state encoding for the game round sequencer.
package game_pkg;

    localparam int STATE_W = 3;
    localparam int LIVES_W = 2;
    localparam int CNT_W   = 8;

    localparam int DEF_LIVES        = 3;
    localparam int DEF_DEATH_FRAMES = 120;
    localparam int DEF_GRACE_FRAMES = 60;

    typedef enum logic [STATE_W-1:0] {
        WAIT_START = 3'd0,
        PLAY       = 3'd1,
        DYING      = 3'd2,
        RESPAWN    = 3'd3,
        GAME_OVER  = 3'd4,
        WIN        = 3'd5
    } state_t;

endpackage

// File: rtl/frame_timer.sv
// 8-bit frame counter advanced by frame_tick; counts up or down, never wraps.
module frame_timer
    import game_pkg::*;
#(
    parameter bit DOWN = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             en,
    input  logic             load,
    input  logic             clear,
    input  logic [CNT_W-1:0] load_val,
    input  logic [CNT_W-1:0] target,
    output logic [CNT_W-1:0] count,
    output logic             done
);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && tick) begin
            if (DOWN) begin
                if (count != '0)
                    count <= count - 1'b1;
            end else if (count != '1) begin
                count <= count + 1'b1;
            end
        end
    end

    assign done = (count == target);

endmodule

// File: rtl/game_flow_ctrl.sv
// Round lifecycle sequencer: start, play, death hold, respawn, game over, win.
// All outputs are registered from the next-state decode.
module game_flow_ctrl
    import game_pkg::*;
#(
    parameter int LIVES        = DEF_LIVES,
    parameter int DEATH_FRAMES = DEF_DEATH_FRAMES,
    parameter int GRACE_FRAMES = DEF_GRACE_FRAMES
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_tick,
    input  logic               move_req,
    input  logic               restart_req,
    input  logic               death_in,
    input  logic               all_enemies_dead,
    output logic               enemy_start,
    output logic               freeze,
    output logic               respawn,
    output logic [LIVES_W-1:0] lives,
    output logic [STATE_W-1:0] state,
    output logic               show_dead,
    output logic               show_game_over,
    output logic               show_win
);

    localparam logic [CNT_W-1:0]   DEATH_LAST = CNT_W'(DEATH_FRAMES - 1);
    localparam logic [CNT_W-1:0]   GRACE_VAL  = CNT_W'(GRACE_FRAMES);
    localparam logic [LIVES_W-1:0] LIVES_VAL  = LIVES_W'(LIVES);

    state_t             cur, nxt;
    logic [LIVES_W-1:0] lives_n;
    logic               death_clear;
    logic               death_done;
    logic               grace_done;
    logic [CNT_W-1:0]   death_cnt;
    logic [CNT_W-1:0]   grace_cnt;

    frame_timer #(.DOWN(1'b0)) u_death (
        .clk      (clk),
        .reset    (reset),
        .tick     (frame_tick),
        .en       (cur == DYING),
        .load     (1'b0),
        .clear    (death_clear),
        .load_val ('0),
        .target   (DEATH_LAST),
        .count    (death_cnt),
        .done     (death_done)
    );

    // Grace only drains while playing, so time spent waiting to start is free.
    frame_timer #(.DOWN(1'b1)) u_grace (
        .clk      (clk),
        .reset    (reset),
        .tick     (frame_tick),
        .en       (cur == PLAY),
        .load     (cur == RESPAWN),
        .clear    (1'b0),
        .load_val (GRACE_VAL),
        .target   ('0),
        .count    (grace_cnt),
        .done     (grace_done)
    );

    always_comb begin
        nxt         = cur;
        lives_n     = lives;
        death_clear = 1'b0;
        unique case (cur)
            WAIT_START: if (move_req) nxt = PLAY;
            PLAY: begin
                if (death_in && grace_done) begin
                    nxt         = DYING;
                    death_clear = 1'b1;
                    if (lives != '0)
                        lives_n = lives - 1'b1;
                end else if (all_enemies_dead) begin
                    nxt = WIN;
                end
            end
            DYING: begin
                if (frame_tick && death_done)
                    nxt = (lives == '0) ? GAME_OVER : RESPAWN;
            end
            RESPAWN: nxt = WAIT_START;
            GAME_OVER, WIN: begin
                if (restart_req) begin
                    nxt     = RESPAWN;
                    lives_n = LIVES_VAL;
                end
            end
            default: nxt = WAIT_START;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cur            <= WAIT_START;
            lives          <= LIVES_VAL;
            enemy_start    <= 1'b0;
            freeze         <= 1'b1;
            respawn        <= 1'b0;
            show_dead      <= 1'b0;
            show_game_over <= 1'b0;
            show_win       <= 1'b0;
        end else begin
            cur            <= nxt;
            lives          <= lives_n;
            enemy_start    <= (nxt == PLAY);
            freeze         <= (nxt != PLAY);
            respawn        <= (nxt == RESPAWN);
            show_dead      <= (nxt == DYING);
            show_game_over <= (nxt == GAME_OVER);
            show_win       <= (nxt == WIN);
        end
    end

    assign state = cur;

endmodule

// File: doc/game_flow_ctrl.md
# game_flow_ctrl

Top-level game sequencer that owns the round lifecycle: start, play, death, respawn, game over and win. It takes the per-frame tick, debounced button activity, the OR'd enemy collision signal and an all-enemies-dead flag. It produces the enemy start enable, a respawn pulse for sprite modules, a freeze flag, the lives count and screen-select flags for the pixel colour mux. It sits beside the display controller and replaces the ad-hoc `game_over || death_signal` colouring with a timed, stateful sequence.

## Interface
- `LIVES`, default 3: lives loaded at reset and at restart; legal range 1..3.
- `DEATH_FRAMES`, default 120: frames the death screen is held; legal range 1..255.
- `GRACE_FRAMES`, default 60: frames after a respawn during which `death_in` is ignored; legal range 0..255.

Ports:
- `clk` in 1: system clock (100 MHz).
- `reset` in 1: synchronous, active-high; one clock domain only.
- `frame_tick` in 1: one-cycle pulse per video frame.
- `move_req` in 1: any debounced direction button held.
- `restart_req` in 1: single-cycle pulse from the centre-button debouncer.
- `death_in` in 1: enemy/bomberman overlap, or bomberman inside an explosion; level signal.
- `all_enemies_dead` in 1: level signal.
- `enemy_start` out 1: enemies may move.
- `freeze` out 1: sprite movement disabled.
- `respawn` out 1: one-cycle pulse that returns sprites to their start positions.
- `lives` out 2: remaining lives.
- `state` out 3: current state encoding.
- `show_dead`, `show_game_over`, `show_win` out 1 each: colour-mux screen selects.

## Operation
States and encodings: WAIT_START=0, PLAY=1, DYING=2, RESPAWN=3, GAME_OVER=4, WIN=5. Encodings 6 and 7 are illegal and go to WAIT_START on the next clock.

Reset values:
- state=WAIT_START, lives=LIVES.
- Frame counter and grace counter = 0.
- All 1-bit outputs = 0, except `freeze`=1.

State behaviour:
- **WAIT_START:** `freeze`=1, `enemy_start`=0.
  - `move_req`=1 → PLAY.
- **PLAY:** `enemy_start`=1, `freeze`=0.
  - `death_in`=1 and grace counter = 0 → DYING. On this transition `lives` decrements, saturating at 0, and the frame counter clears.
  - Otherwise, `all_enemies_dead`=1 → WIN.
  - If both conditions hold in the same cycle, DYING wins.
  - The grace counter decrements by 1 on each `frame_tick` while it is nonzero.
- **DYING:** `show_dead`=1, `freeze`=1, `enemy_start`=0. The frame counter increments on each `frame_tick`.
  - On the tick where the counter equals DEATH_FRAMES-1: if `lives`=0 → GAME_OVER, else → RESPAWN.
- **RESPAWN:** lasts exactly one cycle.
  - `respawn`=1 and the grace counter loads GRACE_FRAMES.
  - Next state is WAIT_START.
- **GAME_OVER:** `show_game_over`=1, `freeze`=1. **WIN:** `show_win`=1, `freeze`=1.
  - In either state, `restart_req` → RESPAWN with `lives` reloaded to LIVES.
- `restart_req` is ignored in every other state.
- `death_in` is ignored outside PLAY.

## Timing
- All outputs are registered; each output reflects the state entered at that edge.
- Input-to-output latency is 1 clock: input sampled at edge N, state and outputs change at edge N+1.
- `respawn` is high for exactly 1 cycle per death (when lives remain) and per restart; it is never asserted back-to-back.
- DYING lasts exactly DEATH_FRAMES `frame_tick`s, counted from the first tick after entry.
  - A tick that arrives in the same cycle as entry is not counted.
- Counters are 8 bits wide and do not wrap.
- A `reset` asserted in any state overrides all other inputs that cycle, including mid-DYING and mid-grace.
- `frame_tick` and `restart_req` arriving in the same cycle are both honoured: the tick has no effect in GAME_OVER or WIN.

## Structure
- Shared package `game_pkg` holds:
  - state encoding localparams and the state width constant (3);
  - the lives width constant (2);
  - default frame constants.
- Sub-module `frame_timer`: an 8-bit counter advanced by `frame_tick`, with a `load` input, a `clear` input and a `done` output when the count equals a target.
  - Two instances: one death hold timer, one grace timer.
- The top-level file instantiates the block and drives the existing colour mux's screen priority from `show_*`.

## Test plan
- Reset, then `move_req`=1 for 1 cycle → `state`=1, `enemy_start`=1 on the following edge, `lives`=3.
- In PLAY, pulse `death_in`, then send 120 `frame_tick`s → `show_dead` held throughout; `respawn` pulses once; `lives`=2; `state`=0.
- Three deaths (`death_in` in PLAY each time) → after the third DYING period, `state`=4 with `show_game_over`=1. `restart_req` → `respawn` pulse, `lives`=3, `state`=0.
- Respawn, then `move_req`, then `death_in` held high → no DYING for 60 ticks; DYING entered on the cycle after the grace counter reaches 0.
- `death_in` and `all_enemies_dead` asserted in the same PLAY cycle → DYING. Later, `all_enemies_dead` alone → `state`=5, `show_win`=1.
- Assert `reset` during DYING at tick 50 → the next edge gives `state`=0, `lives`=3, `show_dead`=0, counters 0.
